// File: rtl/exc_redirect_ctrl_pkg.sv
// exc_redirect_ctrl_pkg: exception type codes, reset vector and FSM encoding shared by the redirect controller
package exc_redirect_ctrl_pkg;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRAIN    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;
    // Interrupts share ExcCode 0; every other type maps straight onto its low bits
    function automatic logic [4:0] excode_of(input logic [31:0] t);
        return (t == EXC_INT) ? 5'd0 : t[4:0];
    endfunction
endpackage

// File: rtl/exc_redirect_ctrl_axi_outst_counter.sv
// axi_outst_counter: saturating up/down count of outstanding AXI requests; cnt_next is the post-update value
module axi_outst_counter #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_next
);
    localparam logic [CNT_W-1:0] MAX = CNT_W'(MAX_OUTST);
    logic [CNT_W-1:0] cnt;
    always_comb begin
        cnt_next = (inc && !dec) ? ((cnt == MAX) ? cnt : cnt + 1'b1) :
                   (dec && !inc) ? ((cnt == '0) ? cnt : cnt - 1'b1) : cnt;
    end
    always_ff @(posedge clk) begin
        if (!resetn) cnt <= '0;
        else         cnt <= cnt_next;
    end
    always @(posedge clk) begin
        if (resetn) begin
            assert (!(inc && !dec && cnt == MAX));
            assert (!(dec && !inc && cnt == '0));
        end
    end
endmodule

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: commits M-stage exceptions/ERET to CP0, flushes the pipe,
// drains stale fetch responses and holds the redirect PC until fetch takes it.
import exc_redirect_ctrl_pkg::*;
module exc_redirect_ctrl #(
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        isexceptM,
    input  logic [31:0] excepttypeM,
    input  logic [31:0] newpcM,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic [31:0] badvaddrM,
    input  logic        data_busy,
    input  logic        inst_req_fire,
    input  logic        inst_resp_fire,
    input  logic        fetch_ready,
    output logic        flush,
    output logic        stall,
    output logic        inst_discard,
    output logic        cp0_exc_we,
    output logic        cp0_eret,
    output logic [4:0]  cp0_excode,
    output logic [31:0] cp0_epc,
    output logic        cp0_bd,
    output logic        cp0_badvaddr_we,
    output logic [31:0] cp0_badvaddr,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);
    state_t           state;
    logic [CNT_W-1:0] cnt_next;
    logic             start, is_eret, is_badv, drain_done;
    axi_outst_counter #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (inst_req_fire),
        .dec      (inst_resp_fire),
        .cnt_next (cnt_next)
    );
    assign start        = (state == ST_IDLE) && isexceptM;
    assign is_eret      = excepttypeM == EXC_ERET;
    assign is_badv      = (excepttypeM == EXC_ADEL) || (excepttypeM == EXC_ADES);
    assign drain_done   = (cnt_next == '0) && !data_busy;
    assign inst_discard = (state == ST_DRAIN) && inst_resp_fire;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= ST_IDLE;
            flush           <= 1'b0;
            stall           <= 1'b0;
            cp0_exc_we      <= 1'b0;
            cp0_eret        <= 1'b0;
            cp0_excode      <= '0;
            cp0_epc         <= '0;
            cp0_bd          <= 1'b0;
            cp0_badvaddr_we <= 1'b0;
            cp0_badvaddr    <= '0;
            redirect_valid  <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            flush           <= start;
            cp0_exc_we      <= start && !is_eret;
            cp0_eret        <= start && is_eret;
            cp0_badvaddr_we <= start && is_badv;
            if (start && !is_eret) begin
                cp0_excode <= excode_of(excepttypeM);
                cp0_bd     <= is_in_delayslotM;
                cp0_epc    <= is_in_delayslotM ? pcM - 32'd4 : pcM;
            end
            if (start && is_badv) cp0_badvaddr <= badvaddrM;
            case (state)
                ST_IDLE: if (isexceptM) begin
                    redirect_pc <= newpcM;
                    stall       <= 1'b1;
                    state       <= drain_done ? ST_REDIRECT : ST_DRAIN;
                end
                ST_DRAIN: if (drain_done) begin
                    state          <= ST_REDIRECT;
                    redirect_valid <= 1'b1;
                end
                // Entered straight from IDLE, valid rises one cycle later to keep the 2-cycle minimum latency
                ST_REDIRECT: if (redirect_valid && fetch_ready) begin
                    state          <= ST_IDLE;
                    redirect_valid <= 1'b0;
                    stall          <= 1'b0;
                end else begin
                    redirect_valid <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
    always @(posedge clk) begin
        if (resetn && isexceptM) assert (excepttypeM != '0);
    end
endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// tb_exc_redirect_ctrl: directed checks of commit pulses, drain, redirect hold and reset abort.
import exc_redirect_ctrl_pkg::*;
module tb_exc_redirect_ctrl;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        isexceptM = 1'b0;
    logic [31:0] excepttypeM = '0;
    logic [31:0] newpcM = '0;
    logic [31:0] pcM = '0;
    logic        is_in_delayslotM = 1'b0;
    logic [31:0] badvaddrM = '0;
    logic        data_busy = 1'b0;
    logic        inst_req_fire = 1'b0;
    logic        inst_resp_fire = 1'b0;
    logic        fetch_ready = 1'b0;
    logic        flush, stall, inst_discard, cp0_exc_we, cp0_eret, cp0_bd, cp0_badvaddr_we, redirect_valid;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_epc, cp0_badvaddr, redirect_pc;
    int tests = 0;
    int fails = 0;

    exc_redirect_ctrl dut (
        .clk(clk), .resetn(resetn), .isexceptM(isexceptM), .excepttypeM(excepttypeM),
        .newpcM(newpcM), .pcM(pcM), .is_in_delayslotM(is_in_delayslotM), .badvaddrM(badvaddrM),
        .data_busy(data_busy), .inst_req_fire(inst_req_fire), .inst_resp_fire(inst_resp_fire),
        .fetch_ready(fetch_ready), .flush(flush), .stall(stall), .inst_discard(inst_discard),
        .cp0_exc_we(cp0_exc_we), .cp0_eret(cp0_eret), .cp0_excode(cp0_excode), .cp0_epc(cp0_epc),
        .cp0_bd(cp0_bd), .cp0_badvaddr_we(cp0_badvaddr_we), .cp0_badvaddr(cp0_badvaddr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic raise(input logic [31:0] t, input logic [31:0] npc, input logic [31:0] pc,
                         input logic ds, input logic [31:0] bva);
        isexceptM = 1'b1; excepttypeM = t; newpcM = npc; pcM = pc; is_in_delayslotM = ds; badvaddrM = bva;
    endtask

    task automatic accept();
        fetch_ready = 1'b1;
        tick();
        fetch_ready = 1'b0;
        chk("accept_valid_low", {31'd0, redirect_valid}, 32'd0);
        chk("accept_stall_low", {31'd0, stall}, 32'd0);
    endtask

    initial begin
        tick(); tick();
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_stall", {31'd0, stall}, 0);
        chk("rst_exc_we", {31'd0, cp0_exc_we}, 0);
        chk("rst_eret", {31'd0, cp0_eret}, 0);
        chk("rst_valid", {31'd0, redirect_valid}, 0);
        chk("rst_pc", redirect_pc, 0);
        chk("rst_epc", cp0_epc, 0);
        chk("rst_cnt", 32'(dut.u_cnt.cnt), 0);
        resetn = 1'b1;
        tick();
        // syscall on an idle bus
        raise(EXC_SYS, EXC_VEC, 32'hbfc00100, 1'b0, 32'h0);
        tick();
        isexceptM = 1'b0;
        chk("sys_flush", {31'd0, flush}, 1);
        chk("sys_exc_we", {31'd0, cp0_exc_we}, 1);
        chk("sys_eret", {31'd0, cp0_eret}, 0);
        chk("sys_excode", 32'(cp0_excode), 8);
        chk("sys_epc", cp0_epc, 32'hbfc00100);
        chk("sys_bd", {31'd0, cp0_bd}, 0);
        chk("sys_bva_we", {31'd0, cp0_badvaddr_we}, 0);
        chk("sys_stall", {31'd0, stall}, 1);
        chk("sys_valid_t1", {31'd0, redirect_valid}, 0);
        tick();
        chk("sys_flush_pulse", {31'd0, flush}, 0);
        chk("sys_exc_we_pulse", {31'd0, cp0_exc_we}, 0);
        chk("sys_valid_t2", {31'd0, redirect_valid}, 1);
        chk("sys_rpc", redirect_pc, 32'hbfc00380);
        accept();
        // back-to-back delay-slot AdEL in the first IDLE cycle
        raise(EXC_ADEL, EXC_VEC, 32'h80001004, 1'b1, 32'h80001003);
        tick();
        isexceptM = 1'b0;
        chk("adel_flush", {31'd0, flush}, 1);
        chk("adel_excode", 32'(cp0_excode), 4);
        chk("adel_epc", cp0_epc, 32'h80001000);
        chk("adel_bd", {31'd0, cp0_bd}, 1);
        chk("adel_bva_we", {31'd0, cp0_badvaddr_we}, 1);
        chk("adel_bva", cp0_badvaddr, 32'h80001003);
        tick();
        chk("adel_valid", {31'd0, redirect_valid}, 1);
        accept();
        // interrupt maps to ExcCode 0
        raise(EXC_INT, EXC_VEC, 32'h80002000, 1'b0, 32'h0);
        tick();
        isexceptM = 1'b0;
        chk("int_excode", 32'(cp0_excode), 0);
        chk("int_exc_we", {31'd0, cp0_exc_we}, 1);
        tick();
        accept();
        // drain two outstanding fetches
        inst_req_fire = 1'b1;
        tick(); tick();
        inst_req_fire = 1'b0;
        chk("drain_cnt2", 32'(dut.u_cnt.cnt), 2);
        raise(EXC_OV, EXC_VEC, 32'h80003000, 1'b0, 32'h0);
        tick();
        isexceptM = 1'b0;
        chk("drain_flush", {31'd0, flush}, 1);
        tick();
        chk("drain_t2_disc", {31'd0, inst_discard}, 0);
        chk("drain_t2_valid", {31'd0, redirect_valid}, 0);
        tick();
        inst_resp_fire = 1'b1;
        #1;
        chk("drain_t3_disc", {31'd0, inst_discard}, 1);
        tick();
        inst_resp_fire = 1'b0;
        #1;
        chk("drain_t4_disc", {31'd0, inst_discard}, 0);
        chk("drain_t4_valid", {31'd0, redirect_valid}, 0);
        tick();
        inst_resp_fire = 1'b1;
        #1;
        chk("drain_t5_disc", {31'd0, inst_discard}, 1);
        tick();
        inst_resp_fire = 1'b0;
        chk("drain_t6_valid", {31'd0, redirect_valid}, 1);
        chk("drain_cnt0", 32'(dut.u_cnt.cnt), 0);
        accept();
        // ERET with the data side busy for four cycles
        raise(EXC_ERET, 32'h80000200, 32'h80004000, 1'b0, 32'h0);
        data_busy = 1'b1;
        tick();
        isexceptM = 1'b0;
        chk("eret_pulse", {31'd0, cp0_eret}, 1);
        chk("eret_no_exc_we", {31'd0, cp0_exc_we}, 0);
        chk("eret_flush", {31'd0, flush}, 1);
        tick();
        chk("eret_pulse_end", {31'd0, cp0_eret}, 0);
        chk("eret_t2_valid", {31'd0, redirect_valid}, 0);
        tick();
        chk("eret_t3_valid", {31'd0, redirect_valid}, 0);
        tick();
        data_busy = 1'b0;
        chk("eret_t4_valid", {31'd0, redirect_valid}, 0);
        tick();
        chk("eret_t5_valid", {31'd0, redirect_valid}, 1);
        chk("eret_rpc", redirect_pc, 32'h80000200);
        // backpressure with an ignored exception
        for (int i = 0; i < 6; i++) begin
            if (i == 2) raise(EXC_SYS, 32'h12345678, 32'h80005000, 1'b0, 32'h0);
            tick();
            isexceptM = 1'b0;
            chk("bp_valid", {31'd0, redirect_valid}, 1);
            chk("bp_rpc", redirect_pc, 32'h80000200);
            chk("bp_flush", {31'd0, flush}, 0);
            chk("bp_exc_we", {31'd0, cp0_exc_we}, 0);
        end
        accept();
        // simultaneous request and response
        inst_req_fire = 1'b1;
        tick();
        chk("sim_cnt1", 32'(dut.u_cnt.cnt), 1);
        inst_resp_fire = 1'b1;
        tick();
        chk("sim_cnt_hold", 32'(dut.u_cnt.cnt), 1);
        inst_req_fire = 1'b0;
        tick();
        inst_resp_fire = 1'b0;
        chk("sim_cnt0", 32'(dut.u_cnt.cnt), 0);
        // reset in the middle of a drain
        inst_req_fire = 1'b1;
        tick();
        inst_req_fire = 1'b0;
        raise(EXC_BP, EXC_VEC, 32'h80006000, 1'b0, 32'h0);
        tick();
        isexceptM = 1'b0;
        chk("rd_stall", {31'd0, stall}, 1);
        chk("rd_state", 32'(dut.state), 32'(ST_DRAIN));
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("rd_state_idle", 32'(dut.state), 32'(ST_IDLE));
        chk("rd_cnt", 32'(dut.u_cnt.cnt), 0);
        chk("rd_stall0", {31'd0, stall}, 0);
        chk("rd_excode", 32'(cp0_excode), 0);
        chk("rd_epc", cp0_epc, 0);
        chk("rd_rpc", redirect_pc, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_no_redirect", {31'd0, redirect_valid}, 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exc_redirect_ctrl.md
Name: exc_redirect_ctrl

Overview:
- Sequences the commit of an exception or ERET raised by the M-stage exception unit.
- Issues a one-cycle CP0 commit strobe and flushes F through M.
- Drains in-flight AXI instruction-fetch responses and discards them.
- Holds the redirect PC (0xbfc00380 or EPC) until the fetch stage accepts it.
- Sits between the exception unit, the CP0 block, the hazard unit and the AXI fetch interface.

Parameters:
- MAX_OUTST, 4, maximum outstanding instruction-fetch requests on AXI.
- CNT_W, 3, outstanding-counter width; must satisfy 2^CNT_W > MAX_OUTST.

Ports:
- clk  in  1  core clock
- resetn  in  1  synchronous reset, active-low
- isexceptM  in  1  exception or ERET present in M
- excepttypeM  in  32  type code (1 int, 4 adel, 5 ades, 8 sys, 9 bp, a ri, c ov, e eret)
- newpcM  in  32  redirect target
- pcM  in  32  PC of the M instruction
- is_in_delayslotM  in  1  M instruction is in a branch delay slot
- badvaddrM  in  32  faulting address (valid for types 4/5)
- data_busy  in  1  data-side AXI transaction outstanding
- inst_req_fire  in  1  fetch request handshake this cycle (arvalid & arready)
- inst_resp_fire  in  1  fetch response handshake this cycle (rvalid & rready & rlast)
- fetch_ready  in  1  fetch stage accepts the redirect this cycle
- flush  out  1  one-cycle pulse; clears F/D/E/M pipeline registers
- stall  out  1  freezes PC and fetch issue while a commit is in progress
- inst_discard  out  1  marks the current instruction response as stale; the fetch stage drops it
- cp0_exc_we  out  1  one-cycle pulse; CP0 records an exception
- cp0_eret  out  1  one-cycle pulse; CP0 clears Status.EXL
- cp0_excode  out  5  Cause.ExcCode
- cp0_epc  out  32  EPC value
- cp0_bd  out  1  Cause.BD
- cp0_badvaddr_we  out  1  BadVAddr write enable (asserted with cp0_exc_we)
- cp0_badvaddr  out  32  BadVAddr value
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target, held stable

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State goes to IDLE; the outstanding counter, all pulses and redirect_valid clear to 0.
  - redirect_pc, cp0_epc and cp0_badvaddr clear to 0; cp0_excode and cp0_bd clear to 0.
  - Reset mid-sequence aborts the sequence without issuing a redirect.
- Outstanding counter:
  - Increments on inst_req_fire and decrements on inst_resp_fire; both in the same cycle leave it unchanged.
  - Counts in every state.
  - An increment at MAX_OUTST or a decrement at 0 is illegal; it is asserted in simulation, and the counter saturates in RTL.
- States: IDLE, DRAIN, REDIRECT.
- IDLE, cycle T with isexceptM=1:
  - At T+1, flush=1 for one cycle.
  - If type != 0xe: cp0_exc_we=1 for one cycle, cp0_excode=type[4:0] except type 1 maps to 0.
    - cp0_bd=is_in_delayslotM.
    - cp0_epc = pcM-4 if is_in_delayslotM, else pcM.
    - For types 4/5, cp0_badvaddr_we=1 with cp0_badvaddr=badvaddrM.
  - If type == 0xe: cp0_eret=1 for one cycle; cp0_exc_we=0.
  - newpcM is latched into redirect_pc.
  - Next state: DRAIN if the counter (after T's update) != 0 or data_busy=1; otherwise REDIRECT.
  - stall=1 from T+1 until the redirect handshake completes.
- DRAIN:
  - inst_discard = inst_resp_fire.
  - inst_req_fire is not expected because stall=1; if it occurs, it is still counted.
  - Leave for REDIRECT in the first cycle where counter==0 and data_busy==0 (evaluated after the update).
- REDIRECT:
  - redirect_valid=1, with redirect_pc held.
  - On fetch_ready=1: go to IDLE next cycle, and redirect_valid and stall drop to 0.
  - fetch_ready=0 holds indefinitely with redirect_pc unchanged.
- isexceptM is ignored outside IDLE, because the pipeline is flushed and frozen.
- Back-to-back: an exception in the first IDLE cycle after a redirect is accepted normally.
- Minimum latency from isexceptM to redirect_valid is 2 cycles (nothing outstanding).
- An exception with excepttypeM==0 while isexceptM=1 is illegal; it is asserted in simulation.

Decomposition:
- Shared package holds:
  - excepttype codes (EXC_INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=0xa, OV=0xc, ERET=0xe)
  - exception vector 0xbfc00380
  - state encoding
- One sub-module, axi_outst_counter: the up/down counter with saturation and its assertions. It is reused on the data side later.

Test Plan:
- Syscall, idle bus:
  - Stimulus: isexceptM=1, type=8, pcM=0xbfc00100, not in delay slot.
  - Required response: next cycle flush=1, cp0_exc_we=1, excode=8, epc=0xbfc00100, bd=0; the cycle after, redirect_valid=1, redirect_pc=0xbfc00380; fetch_ready=1 returns to IDLE.
- Delay-slot AdEL:
  - Stimulus: type=4, pcM=0x80001004, delay slot, badvaddrM=0x80001003.
  - Required response: epc=0x80001000, bd=1, cp0_badvaddr_we=1, cp0_badvaddr=0x80001003, excode=4.
- Drain:
  - Stimulus: 2 fetch requests outstanding; exception raised; responses arrive 3 and 5 cycles later.
  - Required response: inst_discard=1 on exactly those 2 cycles; redirect_valid rises the cycle after the second response.
- ERET with data_busy:
  - Stimulus: type=0xe, newpcM=0x80000200, data_busy=1 for 4 cycles.
  - Required response: cp0_eret pulse, no cp0_exc_we; stays in DRAIN 4 cycles; then redirect_pc=0x80000200.
- Redirect backpressure and ignored exception:
  - Stimulus: fetch_ready=0 for 6 cycles; a new isexceptM during that time.
  - Required response: redirect_valid and redirect_pc stable; the second exception is ignored (no extra pulses).
- Reset mid-DRAIN:
  - Stimulus: resetn=0 for one cycle.
  - Required response: all outputs 0; state IDLE; counter 0.
- Simultaneous inst_req_fire and inst_resp_fire:
  - Required response: counter unchanged.
